// File: rtl/led_pkg.sv
// Shared definitions for the LED chaser: mode encodings, bounce direction
// and the pattern mask helper.
package led_pkg;

  localparam int unsigned MAX_LEDS = 64;

  localparam logic [1:0] MODE_ROT_L  = 2'd0;
  localparam logic [1:0] MODE_ROT_R  = 2'd1;
  localparam logic [1:0] MODE_BOUNCE = 2'd2;
  localparam logic [1:0] MODE_BAR    = 2'd3;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // Active-high mask: BAR lights 0..pos, every other mode lights only pos.
  function automatic logic [MAX_LEDS-1:0] pattern(input logic [1:0]  mode,
                                                  input int unsigned pos,
                                                  input int unsigned n);
    logic [MAX_LEDS-1:0] mask;
    mask = '0;
    for (int unsigned i = 0; i < MAX_LEDS; i++) begin
      if (i < n) mask[i] = (mode == MODE_BAR) ? (i <= pos) : (i == pos);
    end
    return mask;
  endfunction

endpackage

// File: rtl/led_prescaler.sv
// Step-period prescaler: counts sys_clk cycles up to (TICK_CYCLES >> speed) - 1
// and flags the terminal count combinationally.
module led_prescaler #(
  parameter int unsigned TICK_CYCLES = 13_500_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [1:0] speed,
  input  logic       pause,
  input  logic       clear,
  output logic       tick_c
);

  localparam int unsigned CW = $clog2(TICK_CYCLES + 1);
  localparam logic [31:0] TC = 32'(TICK_CYCLES);

  logic [CW-1:0] cnt;
  logic [CW-1:0] term_c;

  if (TICK_CYCLES < 8) begin : g_bad_tick
    $error("led_prescaler: TICK_CYCLES must be >= 8");
  end

  // >= rather than == so a speed-up past the current count fires at once.
  assign term_c = CW'((TC >> speed) - 32'd1);
  assign tick_c = (cnt >= term_c);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (!pause) begin
      cnt <= tick_c ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/led_chaser.sv
// Parametrised LED pattern engine: rotate left/right, bounce and bar patterns
// on an active-low LED bank, with pause, single-step and a step strobe.
module led_chaser
  import led_pkg::*;
#(
  parameter int unsigned N_LEDS      = 6,
  parameter int unsigned TICK_CYCLES = 13_500_000
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [1:0]        mode,
  input  logic [1:0]        speed,
  input  logic              pause,
  input  logic              step,
  output logic [N_LEDS-1:0] led,
  output logic              step_o
);

  localparam int unsigned PW = $clog2(N_LEDS);
  localparam logic [PW-1:0] LAST = PW'(N_LEDS - 1);

  if (N_LEDS < 2 || N_LEDS > MAX_LEDS) begin : g_bad_n
    $error("led_chaser: N_LEDS must be in 2..64");
  end

  logic [PW-1:0]       pos, pos_n;
  dir_e                dir, dir_n;
  logic [1:0]          mode_q, mode_n, pat_mode;
  logic [N_LEDS-1:0]   led_n;
  logic                step_n;
  logic                tick_c, mode_chg_c, advance_c;
  logic [MAX_LEDS-1:0] mask_c;

  assign mode_chg_c = (mode != mode_q);
  assign advance_c  = (tick_c & ~pause) | step;

  led_prescaler #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_prescaler (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .speed  (speed),
    .pause  (pause),
    .clear  (mode_chg_c),
    .tick_c (tick_c)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      pos    <= '0;
      dir    <= DIR_UP;
      mode_q <= MODE_ROT_L;
      led    <= ~N_LEDS'(1);
      step_o <= 1'b0;
    end else begin
      pos    <= pos_n;
      dir    <= dir_n;
      mode_q <= mode_n;
      led    <= led_n;
      step_o <= step_n;
    end
  end

  // Mode change wins over advance; led always reflects the next position.
  always_comb begin
    pos_n    = pos;
    dir_n    = dir;
    mode_n   = mode_q;
    led_n    = led;
    step_n   = 1'b0;
    pat_mode = mode_q;

    if (mode_chg_c) begin
      mode_n   = mode;
      pos_n    = '0;
      dir_n    = DIR_UP;
      pat_mode = mode;
    end else if (advance_c) begin
      step_n = 1'b1;
      case (mode_q)
        MODE_ROT_R: pos_n = (pos == '0) ? LAST : pos - PW'(1);
        MODE_BOUNCE: begin
          if (dir == DIR_UP) begin
            if (pos == LAST) begin
              dir_n = DIR_DOWN;
              pos_n = pos - PW'(1);
            end else begin
              pos_n = pos + PW'(1);
            end
          end else begin
            if (pos == '0) begin
              dir_n = DIR_UP;
              pos_n = PW'(1);
            end else begin
              pos_n = pos - PW'(1);
            end
          end
        end
        default: pos_n = (pos == LAST) ? '0 : pos + PW'(1);
      endcase
    end

    mask_c = pattern(pat_mode, 32'(pos_n), N_LEDS);
    if (mode_chg_c || advance_c) led_n = ~mask_c[N_LEDS-1:0];
  end

endmodule

// File: doc/led_chaser.md
# led_chaser

Parametrised LED pattern engine driving an active-low LED bank on the board top level. It succeeds the fixed 6-LED single-pattern chaser with a configurable LED count, a configurable step period with a run-time speed select, and four selectable patterns. It also adds pause and manual single-step and provides a step strobe for other logic.

## Interface
- N_LEDS, 6: LED count; must be >= 2 (elaboration error otherwise).
- TICK_CYCLES, 13_500_000: base step period in sys_clk cycles (0.5 s at 27 MHz); must be >= 8.
- sys_clk  in  1  system clock.
- sys_rst  in  1  reset. One clock; reset is synchronous and active-high.
- mode  in  2  pattern: 0 ROT_L, 1 ROT_R, 2 BOUNCE, 3 BAR.
- speed  in  2  period divisor: step period = TICK_CYCLES >> speed.
- pause  in  1  level; freezes prescaler and pattern while high.
- step  in  1  single-cycle pulse; forces one advance.
- led  out  N_LEDS  LED drive, active-low (0 = lit), registered.
- step_o  out  1  registered pulse, high for the cycle after each advance.

## Operation
- State: prescaler cnt, position pos (0..N_LEDS-1), direction dir (up/down), mode_q (registered mode).
- Reset values: cnt=0, pos=0, dir=up, mode_q=0, led = all ones except led[0]=0, step_o=0.
- Prescaler terminal: term = (TICK_CYCLES >> speed) - 1. Each non-paused cycle: if cnt >= term then cnt<=0 and a tick fires; else cnt<=cnt+1. The >= compare lets a speed increase mid-count terminate at once.
- Advance = (tick & ~pause) | step. A step that coincides with a tick gives one advance only. A step while paused advances but leaves cnt unchanged.
- Advance rules:
  - ROT_L: pos <= (pos+1) mod N_LEDS.
  - ROT_R: pos <= (pos-1) mod N_LEDS.
  - BOUNCE: moves in direction dir. At pos = N_LEDS-1 going up, dir flips and pos goes to N_LEDS-2. The mirror rule applies at 0. End positions are never repeated.
  - BAR: pos <= (pos+1) mod N_LEDS.
- Pattern: ROT_L/ROT_R/BOUNCE light only LED[pos]; BAR lights LEDs 0..pos.
- led and pos load on the same edge. led is a register loaded with ~pattern(mode_q, next pos).
- Mode change: when mode != mode_q, the same edge does mode_q<=mode, pos<=0, dir<=up, cnt<=0, led<=~pattern(mode,0). No step_o pulse. This overrides tick and step in that cycle.
- Priority: sys_rst > mode change > advance > hold.
- pause does not block a mode change.

## Timing
- From reset release, the first advance lands on the (term+1)-th rising edge. step_o is high for exactly that following cycle.
- Steady-state step period = term+1 cycles. Each step is exactly one led update and one step_o pulse.
- Latency of the step input to the led change: 1 cycle.
- Reset asserted mid-pattern: all state returns to reset values at the next edge, regardless of other inputs.
- speed changed to a shorter period with cnt >= new term: tick on the next edge.
- speed changed to a longer period: the current count continues toward the new term.

## Structure
- Package led_pkg holds:
  - the mode encoding constants MODE_ROT_L/ROT_R/BOUNCE/BAR;
  - a function pattern(mode, pos, N) returning the active-high mask.
- Sub-module led_prescaler (inputs: TICK_CYCLES, speed, pause, clear; output: tick).
- The top module holds the position/direction FSM, mode-change detection and the output registers.
- Estimated 150–250 lines of RTL.

## Test plan
All cases use N_LEDS=6 and TICK_CYCLES=8.
- Reset, ROT_L, speed=0 -> led=111110, then 111101 on edge 8, 111011 on edge 16. The sequence wraps from 011111 back to 111110. step_o pulses every 8 cycles.
- ROT_R from reset -> first advance gives 011111, then 101111.
- BOUNCE -> pos sequence 0,1,2,3,4,5,4,3,2,1,0,1, with no duplicated 5 or 0.
- BAR -> 111110, 111100, 111000, 110000, 100000, 000000, then 111110.
- Speed change: speed=0 with cnt reaching 5, then set speed=3 (term=0). The next edge produces a tick, followed by one advance per cycle. With speed=2, step every 2 cycles.
- Pause, step and mode change:
  - pause=1 for 40 cycles -> led is frozen and step_o=0.
  - A step pulse while paused -> exactly one advance 1 cycle later.
  - Switch mode to BAR mid-run -> the next edge gives led=111110, cnt=0, and no step_o.
  - Assert sys_rst during BOUNCE going down -> led=111110 and dir=up.
